// File: rtl/i2c_middle_pkg.sv
// rtl/i2c_middle_pkg.sv - shared FSM states, command and status codes for i2c_middle
package i2c_middle_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t ADDR  = 3'd1;
    localparam state_t LEN   = 3'd2;
    localparam state_t WDATA = 3'd3;
    localparam state_t DRAIN = 3'd4;
    localparam state_t ISSUE = 3'd5;
    localparam state_t XFER  = 3'd6;
    localparam state_t RESP  = 3'd7;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    localparam logic [7:0] RSP_OK       = 8'h00;
    localparam logic [7:0] RSP_NACK     = 8'h01;
    localparam logic [7:0] RSP_OVERFLOW = 8'h02;
    localparam logic [7:0] RSP_RD_ABORT = 8'hFF;

    // States in which the switch side may hand us bytes.
    function automatic logic accepts_bytes(input state_t s);
        return (s == IDLE) || (s == ADDR) || (s == LEN) || (s == WDATA) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/i2c_middle_sync_fifo.sv
// rtl/i2c_middle_sync_fifo.sv - single-clock FIFO with occupancy count and synchronous clear
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/i2c_middle.sv
// rtl/i2c_middle.sv - switch byte-stream to I2C master command/data bridge
module i2c_middle
    import i2c_middle_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] STATUS_OK  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_axis_tvalid,
    input  logic [7:0] sw_axis_tdata,
    input  logic       sw_axis_tlast,
    output logic       sw_axis_tready,
    output logic       m_axis_tvalid,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tlast,
    input  logic       m_axis_tready,
    output logic       i2c_cmd_valid,
    input  logic       i2c_cmd_ready,
    output logic       i2c_cmd_rw,
    output logic [6:0] i2c_cmd_addr,
    output logic [7:0] i2c_cmd_len,
    output logic       i2c_wr_tvalid,
    output logic [7:0] i2c_wr_tdata,
    input  logic       i2c_wr_tready,
    input  logic       i2c_rd_tvalid,
    input  logic [7:0] i2c_rd_tdata,
    input  logic       i2c_done,
    input  logic       i2c_nack
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t        state;
    state_t        state_d;
    logic          hold;
    logic          is_rd;
    logic [6:0]    slv_addr;
    logic [7:0]    rd_len;
    logic [7:0]    rd_cnt;
    logic [7:0]    rd_cnt_nx;
    logic          ovf;
    logic          nack_flag;
    logic          pend_ff;
    logic          acc;
    logic          slot_free;
    logic          rd_take;
    logic          resp_go;
    logic [7:0]    resp_code;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_clear;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;

    assign acc        = sw_axis_tvalid && sw_axis_tready;
    assign slot_free  = !m_axis_tvalid || m_axis_tready;
    assign rd_take    = (state == XFER) && is_rd && i2c_rd_tvalid && slot_free && !pend_ff && (rd_cnt < rd_len);
    assign rd_cnt_nx  = rd_cnt + (rd_take ? 8'd1 : 8'd0);
    assign resp_go    = (state == RESP) && slot_free && !pend_ff;
    assign resp_code  = nack_flag ? RSP_NACK : (ovf ? RSP_OVERFLOW : STATUS_OK);

    assign fifo_push  = acc && (state == WDATA) && !fifo_full;
    assign fifo_pop   = i2c_wr_tvalid && i2c_wr_tready;
    // Anything the slave did not take is discarded once the transfer ends.
    assign fifo_clear = (state == XFER) && i2c_done;

    assign i2c_cmd_valid = (state == ISSUE);
    assign i2c_cmd_rw    = is_rd;
    assign i2c_cmd_addr  = slv_addr;
    assign i2c_cmd_len   = is_rd ? rd_len : 8'(fifo_count);
    assign i2c_wr_tvalid = (state == XFER) && !is_rd && !fifo_empty;
    assign i2c_wr_tdata  = i2c_wr_tvalid ? fifo_head : 8'h00;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data (sw_axis_tdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (acc && !sw_axis_tlast)
                       state_d = (sw_axis_tdata == CMD_READ || sw_axis_tdata == CMD_WRITE) ? ADDR : DRAIN;
            ADDR:  if (acc) state_d = sw_axis_tlast ? IDLE : (is_rd ? LEN : WDATA);
            LEN:   if (acc) state_d = (sw_axis_tdata == 8'd0) ? IDLE : ISSUE;
            WDATA: if (acc && sw_axis_tlast) state_d = ISSUE;
            DRAIN: if (acc && sw_axis_tlast) state_d = IDLE;
            ISSUE: if (i2c_cmd_ready) state_d = XFER;
            XFER:  if (i2c_done) state_d = is_rd ? IDLE : RESP;
            RESP:  if (resp_go) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            sw_axis_tready <= 1'b0;
            hold           <= 1'b0;
            is_rd          <= 1'b0;
            slv_addr       <= '0;
            rd_len         <= '0;
            rd_cnt         <= '0;
            ovf            <= 1'b0;
            nack_flag      <= 1'b0;
            pend_ff        <= 1'b0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tdata   <= '0;
            m_axis_tlast   <= 1'b0;
        end else begin
            state <= state_d;

            // Two dead cycles after every accepted byte; otherwise ready follows the next state.
            if (acc) begin
                sw_axis_tready <= 1'b0;
                hold           <= 1'b1;
            end else if (hold) begin
                hold <= 1'b0;
            end else begin
                sw_axis_tready <= accepts_bytes(state_d);
            end

            if (acc && state == IDLE)  is_rd    <= (sw_axis_tdata == CMD_READ);
            if (acc && state == ADDR)  slv_addr <= sw_axis_tdata[6:0];
            if (acc && state == LEN)   rd_len   <= sw_axis_tdata;
            if (acc && state == WDATA && fifo_full) ovf <= 1'b1;

            if (state == ISSUE) rd_cnt <= '0;
            else                rd_cnt <= rd_cnt_nx;

            if (resp_go) begin
                ovf       <= 1'b0;
                nack_flag <= 1'b0;
            end

            if (slot_free) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                if (pend_ff) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= RSP_RD_ABORT;
                    m_axis_tlast  <= 1'b1;
                    pend_ff       <= 1'b0;
                end else if (resp_go) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= resp_code;
                    m_axis_tlast  <= 1'b1;
                end else if (rd_take) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= i2c_rd_tdata;
                    m_axis_tlast  <= (rd_cnt_nx == rd_len);
                end
            end

            // A NACKed read that came up short is closed with a single 0xFF marker.
            if (state == XFER && i2c_done) begin
                nack_flag <= i2c_nack;
                if (is_rd && i2c_nack && rd_cnt_nx < rd_len) pend_ff <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_middle.sv
// tb/tb_i2c_middle.sv - randomized self-checking bench for i2c_middle
module tb_i2c_middle;

    logic       clk;
    logic       rst;
    logic       sw_axis_tvalid;
    logic [7:0] sw_axis_tdata;
    logic       sw_axis_tlast;
    logic       sw_axis_tready;
    logic       m_axis_tvalid;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tlast;
    logic       m_axis_tready;
    logic       i2c_cmd_valid;
    logic       i2c_cmd_ready;
    logic       i2c_cmd_rw;
    logic [6:0] i2c_cmd_addr;
    logic [7:0] i2c_cmd_len;
    logic       i2c_wr_tvalid;
    logic [7:0] i2c_wr_tdata;
    logic       i2c_wr_tready;
    logic       i2c_rd_tvalid;
    logic [7:0] i2c_rd_tdata;
    logic       i2c_done;
    logic       i2c_nack;

    i2c_middle #(
        .FIFO_DEPTH(16),
        .STATUS_OK (8'h00)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sw_axis_tvalid (sw_axis_tvalid),
        .sw_axis_tdata  (sw_axis_tdata),
        .sw_axis_tlast  (sw_axis_tlast),
        .sw_axis_tready (sw_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .i2c_cmd_valid  (i2c_cmd_valid),
        .i2c_cmd_ready  (i2c_cmd_ready),
        .i2c_cmd_rw     (i2c_cmd_rw),
        .i2c_cmd_addr   (i2c_cmd_addr),
        .i2c_cmd_len    (i2c_cmd_len),
        .i2c_wr_tvalid  (i2c_wr_tvalid),
        .i2c_wr_tdata   (i2c_wr_tdata),
        .i2c_wr_tready  (i2c_wr_tready),
        .i2c_rd_tvalid  (i2c_rd_tvalid),
        .i2c_rd_tdata   (i2c_rd_tdata),
        .i2c_done       (i2c_done),
        .i2c_nack       (i2c_nack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int          acc_cnt = 0;
    int          cmd_seen = 0;
    logic [8:0]  m_q[$];
    logic [15:0] cmd_q[$];
    logic [7:0]  wr_q[$];
    logic [7:0]  tx[$];
    logic [7:0]  rx[$];

    always @(posedge clk) begin
        if (rst && sw_axis_tvalid && sw_axis_tready) acc_cnt <= acc_cnt + 1;
        if (i2c_cmd_valid) cmd_seen <= cmd_seen + 1;
        if (m_axis_tvalid && m_axis_tready) m_q.push_back({m_axis_tlast, m_axis_tdata});
        if (i2c_cmd_valid && i2c_cmd_ready) cmd_q.push_back({i2c_cmd_rw, i2c_cmd_addr, i2c_cmd_len});
        if (i2c_wr_tvalid && i2c_wr_tready) wr_q.push_back(i2c_wr_tdata);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, required finish within cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        failed++;
        $error("FAIL %s: observed timeout expected DUT response", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_mon();
        m_q.delete();
        cmd_q.delete();
        wr_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int k = 0;
        sw_axis_tdata  = d;
        sw_axis_tlast  = l;
        sw_axis_tvalid = 1'b1;
        while (!sw_axis_tready && k < 100) begin
            tick();
            k++;
        end
        if (!sw_axis_tready) timeout("send_ready");
        tick();
        sw_axis_tvalid = 1'b0;
        sw_axis_tlast  = 1'b0;
    endtask

    task automatic send_txn();
        for (int i = 0; i < tx.size(); i++) begin
            send_byte(tx[i], i == tx.size() - 1);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic serve_cmd();
        int k = 0;
        while (!i2c_cmd_valid && k < 100) begin
            tick();
            k++;
        end
        if (!i2c_cmd_valid) timeout("cmd_wait");
        else begin
            repeat ($urandom_range(0, 2)) tick();
            i2c_cmd_ready = 1'b1;
            tick();
            i2c_cmd_ready = 1'b0;
        end
    endtask

    task automatic pulse_done(input logic nack);
        i2c_done = 1'b1;
        i2c_nack = nack;
        tick();
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
    endtask

    task automatic serve_write(input int n, input logic nack);
        int k = 0;
        while (wr_q.size() < n && k < 400) begin
            i2c_wr_tready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        i2c_wr_tready = 1'b0;
        if (wr_q.size() < n) timeout("wr_drain");
        tick();
        check("wr_tvalid_after_drain", 32'(i2c_wr_tvalid), 32'd0);
        pulse_done(nack);
    endtask

    task automatic serve_read(input logic nack);
        for (int i = 0; i < rx.size(); i++) begin
            i2c_rd_tvalid = 1'b1;
            i2c_rd_tdata  = rx[i];
            tick();
            i2c_rd_tvalid = 1'b0;
            tick();
        end
        pulse_done(nack);
    endtask

    task automatic wait_m(input int n);
        int k = 0;
        while (m_q.size() < n && k < 50) begin
            tick();
            k++;
        end
        repeat (3) tick();
    endtask

    // Write model: first 16 payload bytes reach the slave, the rest only raise overflow.
    task automatic run_write_tx(input logic nack);
        int         n;
        int         exp_len;
        logic [7:0] a8;
        logic [7:0] code;
        n       = tx.size() - 2;
        a8      = tx[1];
        exp_len = (n > 16) ? 16 : n;
        code    = nack ? 8'h01 : ((n > 16) ? 8'h02 : 8'h00);
        flush_mon();
        send_txn();
        serve_cmd();
        serve_write(exp_len, nack);
        wait_m(1);
        check("wr_cmd_cnt", 32'(cmd_q.size()), 32'd1);
        if (cmd_q.size() > 0) check("wr_cmd", 32'(cmd_q[0]), 32'({1'b0, a8[6:0], 8'(exp_len)}));
        check("wr_byte_cnt", 32'(wr_q.size()), 32'(exp_len));
        for (int i = 0; i < exp_len && i < wr_q.size(); i++)
            check("wr_byte", 32'(wr_q[i]), 32'(tx[i+2]));
        check("wr_resp_cnt", 32'(m_q.size()), 32'd1);
        if (m_q.size() > 0) check("wr_resp", 32'(m_q[0]), 32'({1'b1, code}));
        check("wr_ready_back", 32'(sw_axis_tready), 32'd1);
    endtask

    // Read model: forward up to len slave bytes, last flagged; a short NACKed read ends in FF.
    task automatic run_read_tx(input logic nack);
        int         len;
        int         got;
        logic [7:0] a8;
        logic [8:0] exp_q[$];
        a8  = tx[1];
        len = int'(tx[2]);
        got = (rx.size() < len) ? rx.size() : len;
        for (int i = 0; i < got; i++) exp_q.push_back({i == len - 1, rx[i]});
        if (nack && rx.size() < len) exp_q.push_back(9'h1FF);
        flush_mon();
        send_txn();
        if (len == 0) begin
            repeat (10) tick();
            check("rd0_no_cmd", 32'(cmd_q.size()), 32'd0);
            check("rd0_ready", 32'(sw_axis_tready), 32'd1);
        end else begin
            serve_cmd();
            serve_read(nack);
            wait_m(exp_q.size());
            check("rd_cmd_cnt", 32'(cmd_q.size()), 32'd1);
            if (cmd_q.size() > 0) check("rd_cmd", 32'(cmd_q[0]), 32'({1'b1, a8[6:0], 8'(len)}));
            check("rd_out_cnt", 32'(m_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < m_q.size(); i++)
                check("rd_out", 32'(m_q[i]), 32'(exp_q[i]));
            check("rd_ready_back", 32'(sw_axis_tready), 32'd1);
        end
    endtask

    initial begin
        int         a0;
        int         c0;
        int         len;
        logic       nack;
        logic [7:0] d0;

        rst = 1'b0;
        sw_axis_tvalid = 1'b0; sw_axis_tdata = 8'h00; sw_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;  i2c_cmd_ready = 1'b0;  i2c_wr_tready = 1'b0;
        i2c_rd_tvalid = 1'b0;  i2c_rd_tdata = 8'h00;  i2c_done = 1'b0; i2c_nack = 1'b0;

        // Reset values and tready one cycle after release
        repeat (3) tick();
        check("rst_tready",   32'(sw_axis_tready), 32'd0);
        check("rst_mvalid",   32'(m_axis_tvalid),  32'd0);
        check("rst_mdata",    32'({m_axis_tlast, m_axis_tdata}), 32'd0);
        check("rst_cmdvalid", 32'(i2c_cmd_valid),  32'd0);
        check("rst_cmdfields",32'({i2c_cmd_rw, i2c_cmd_addr, i2c_cmd_len}), 32'd0);
        check("rst_wr",       32'({i2c_wr_tvalid, i2c_wr_tdata}), 32'd0);
        rst = 1'b1;
        #1;
        check("rel_tready_0", 32'(sw_axis_tready), 32'd0);
        tick();
        check("rel_tready_1", 32'(sw_axis_tready), 32'd1);

        // Basic read 02,22,03
        tx = {8'h02, 8'h22, 8'h03};
        rx = {8'($urandom), 8'($urandom), 8'($urandom)};
        run_read_tx(1'b0);

        // Basic write 01,22,A5,33
        tx = {8'h01, 8'h22, 8'hA5, 8'h33};
        run_write_tx(1'b0);

        // Each byte held valid exactly two cycles
        a0 = acc_cnt;
        tx = {8'h02, 8'h5A, 8'h02};
        flush_mon();
        for (int i = 0; i < 3; i++) begin
            begin
                int k = 0;
                while (!sw_axis_tready && k < 50) begin tick(); k++; end
            end
            sw_axis_tdata = tx[i]; sw_axis_tlast = (i == 2); sw_axis_tvalid = 1'b1;
            tick();
            check("hold_tready_lo1", 32'(sw_axis_tready), 32'd0);
            tick();
            sw_axis_tvalid = 1'b0; sw_axis_tlast = 1'b0;
            check("hold_tready_lo2", 32'(sw_axis_tready), 32'd0);
            tick();
            check("hold_tready_after", 32'(sw_axis_tready), 32'(i < 2));
        end
        check("hold_accept_cnt", 32'(acc_cnt - a0), 32'd3);
        rx = {8'($urandom), 8'($urandom)};
        serve_cmd();
        serve_read(1'b0);
        wait_m(2);
        check("hold_cmd", 32'(cmd_q.size() > 0 ? cmd_q[0] : 16'h0000), 32'({1'b1, 7'h5A, 8'd2}));
        check("hold_out_cnt", 32'(m_q.size()), 32'd2);
        if (m_q.size() == 2) check("hold_out_last", 32'(m_q[1]), 32'({1'b1, rx[1]}));

        // Invalid command is drained without touching I2C
        c0 = cmd_seen;
        tx = {8'h07, 8'h11, 8'h22};
        send_txn();
        repeat (8) tick();
        check("inv_no_cmd", 32'(cmd_seen - c0), 32'd0);
        check("inv_ready", 32'(sw_axis_tready), 32'd1);

        // Write NACK and overflow
        tx = {8'h01, 8'h40, 8'($urandom)};
        run_write_tx(1'b1);
        tx = {8'h01, 8'h33};
        for (int i = 0; i < 18; i++) tx.push_back(8'($urandom));
        run_write_tx(1'b0);

        // Stalled output: later read bytes are dropped, held byte stays stable
        tx = {8'h02, 8'h10, 8'h03};
        flush_mon();
        send_txn();
        serve_cmd();
        m_axis_tready = 1'b0;
        d0 = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            i2c_rd_tvalid = 1'b1;
            i2c_rd_tdata  = (i == 0) ? d0 : ~d0;
            tick();
            i2c_rd_tvalid = 1'b0;
            tick();
            check("stall_hold", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'({2'b10, d0}));
        end
        pulse_done(1'b0);
        m_axis_tready = 1'b1;
        repeat (4) tick();
        check("stall_out_cnt", 32'(m_q.size()), 32'd1);
        if (m_q.size() > 0) check("stall_out", 32'(m_q[0]), 32'({1'b0, d0}));

        // Reset in the middle of a write transfer
        tx = {8'h01, 8'h15, 8'($urandom), 8'($urandom), 8'($urandom)};
        flush_mon();
        send_txn();
        serve_cmd();
        tick();
        check("xrst_pre_wrvalid", 32'(i2c_wr_tvalid), 32'd1);
        rst = 1'b0;
        #1;
        check("xrst_wrvalid", 32'(i2c_wr_tvalid), 32'd0);
        check("xrst_tready", 32'(sw_axis_tready), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        pulse_done(1'b0);
        repeat (5) tick();
        check("xrst_no_resp", 32'(m_q.size()), 32'd0);
        check("xrst_ready", 32'(sw_axis_tready), 32'd1);

        // Randomized mix of reads and writes
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                int n;
                n = $urandom_range(1, 20);
                tx = {8'h01, 8'($urandom)};
                for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
                run_write_tx($urandom_range(0, 3) == 0);
            end else begin
                int prov;
                len  = $urandom_range(0, 5);
                nack = 1'($urandom_range(0, 1));
                prov = nack ? $urandom_range(0, len) : len;
                tx = {8'h02, 8'($urandom), 8'(len)};
                rx.delete();
                for (int i = 0; i < prov; i++) rx.push_back(8'($urandom));
                run_read_tx(nack);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
